// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: byte stream to padded 512-bit SHA-256 blocks as 16 big-endian 32-bit words.
// Optional: define SHA256_PAD_ZERO_LEN_EN to add in_empty, which starts a zero-length message.
module sha256_msg_padder #(
   parameter int CNT_W = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   input  logic        in_last,
`ifdef SHA256_PAD_ZERO_LEN_EN
   input  logic        in_empty,
`endif
   output logic        word_valid,
   input  logic        word_ready,
   output logic [31:0] word_data,
   output logic [3:0]  word_idx,
   output logic        msg_last,
   output logic        busy
);
   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_DATA     = 3'd1;
   localparam logic [2:0] S_PAD_ONE  = 3'd2;
   localparam logic [2:0] S_PAD_ZERO = 3'd3;
   localparam logic [2:0] S_PAD_LEN  = 3'd4;
   localparam logic [2:0] S_DRAIN    = 3'd5;

   logic [2:0]       state_q, state_d;
   logic [5:0]       ptr_q, ptr_d, ptr_n;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [23:0]      asm_q, asm_d;
   logic [31:0]      word_q, word_d;
   logic [3:0]       idx_q, idx_d;
   logic             vld_q, vld_d, last_q, last_d, busy_q, busy_d, fin_q, fin_d, en_q;
   logic             can_adv, acc, gen, adv, load, done, fin_now, empty_go;
   logic [63:0]      len;
   logic [5:0]       len_sh;
   logic [7:0]       byte_v;

`ifdef SHA256_PAD_ZERO_LEN_EN
   assign empty_go = en_q && state_q == S_IDLE && in_empty && !in_valid;
`else
   assign empty_go = 1'b0;
`endif

   // A byte may advance unless it would complete a word while the output register is still occupied
   assign can_adv  = !vld_q || word_ready || ptr_q[1:0] != 2'd3;
   assign in_ready = en_q && (state_q == S_IDLE || state_q == S_DATA) && can_adv;
   assign acc      = in_valid && in_ready;
   assign gen      = (state_q == S_PAD_ONE || state_q == S_PAD_ZERO || state_q == S_PAD_LEN) && can_adv;
   assign adv      = acc || gen;
   assign ptr_n    = ptr_q + 6'd1;
   assign load     = adv && ptr_q[1:0] == 2'd3;
   assign done     = state_q == S_DRAIN && vld_q && word_ready && idx_q == 4'd15;
   assign len      = 64'(cnt_q) << 3;
   assign len_sh   = {~ptr_q[2:0], 3'b000};
   assign byte_v   = acc ? in_data : state_q == S_PAD_ONE ? 8'h80 : state_q == S_PAD_LEN ? len[len_sh +: 8] : 8'h00;
   // The 0x80 placed before byte 56 means this very block is the final one
   assign fin_now  = gen && state_q == S_PAD_ONE && ptr_q < 6'd56;

   // Next-state and datapath update
   always_comb begin
      state_d = acc ? (in_last ? S_PAD_ONE : S_DATA) :
                empty_go ? S_PAD_ONE :
                gen && state_q == S_PAD_ONE ? (ptr_n == 6'd56 ? S_PAD_LEN : S_PAD_ZERO) :
                gen && state_q == S_PAD_ZERO && ptr_n == 6'd56 ? S_PAD_LEN :
                gen && state_q == S_PAD_LEN && ptr_q == 6'd63 ? S_DRAIN :
                done ? S_IDLE : state_q;
      ptr_d   = adv ? ptr_n : ptr_q;
      cnt_d   = done ? '0 : acc ? cnt_q + 1'b1 : cnt_q;
      asm_d   = adv ? {asm_q[15:0], byte_v} : asm_q;
      word_d  = load ? {asm_q, byte_v} : word_q;
      idx_d   = load ? ptr_q[5:2] : idx_q;
      last_d  = load ? (fin_q || fin_now) : last_q;
      vld_d   = load || (vld_q && !word_ready);
      fin_d   = done ? 1'b0 : (fin_now || (gen && state_q != S_PAD_LEN && ptr_q == 6'd63)) ? 1'b1 : fin_q;
      busy_d  = done ? 1'b0 : (acc || empty_go) ? 1'b1 : busy_q;
   end

   // State registers; reset discards any message in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         asm_q   <= '0;
         word_q  <= '0;
         idx_q   <= '0;
         vld_q   <= 1'b0;
         last_q  <= 1'b0;
         fin_q   <= 1'b0;
         busy_q  <= 1'b0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         asm_q   <= asm_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
         vld_q   <= vld_d;
         last_q  <= last_d;
         fin_q   <= fin_d;
         busy_q  <= busy_d;
         en_q    <= 1'b1;
      end
   end

   assign word_valid = vld_q;
   assign word_data  = word_q;
   assign word_idx   = idx_q;
   assign msg_last   = last_q;
   assign busy       = busy_q;
endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: directed and randomized messages checked against a byte-level padding model.
module tb_sha256_msg_padder;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = 8'h00;
   logic        in_last = 1'b0;
`ifdef SHA256_PAD_ZERO_LEN_EN
   logic        in_empty = 1'b0;
`endif
   logic        word_valid;
   logic        word_ready = 1'b1;
   logic [31:0] word_data;
   logic [3:0]  word_idx;
   logic        msg_last;
   logic        busy;

   int checks = 0;
   int failures = 0;

   logic [7:0]  msg[$];
   logic [31:0] exp_d[$];
   logic        exp_l[$];
   logic [31:0] obs_d[$];
   logic [3:0]  obs_i[$];
   logic        obs_l[$];

   sha256_msg_padder dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .in_last(in_last),
`ifdef SHA256_PAD_ZERO_LEN_EN
      .in_empty(in_empty),
`endif
      .word_valid(word_valid),
      .word_ready(word_ready),
      .word_data(word_data),
      .word_idx(word_idx),
      .msg_last(msg_last),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   // Reference: append 0x80, zero fill to 56 mod 64, append 64-bit bit length; the final
   // block's msg_last is known once the 0x80 is placed or once that block starts
   task automatic build_exp();
      logic [7:0]  p[$];
      logic [63:0] bl;
      int          nb, first;
      p = msg;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      bl = 64'(msg.size()) * 64'd8;
      for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
      nb = p.size() / 64;
      first = (msg.size() / 4 > (nb - 1) * 16) ? msg.size() / 4 : (nb - 1) * 16;
      exp_d.delete();
      exp_l.delete();
      for (int w = 0; w < nb * 16; w++) begin
         exp_d.push_back({p[4*w], p[4*w+1], p[4*w+2], p[4*w+3]});
         exp_l.push_back(w >= first);
      end
   endtask

   task automatic run_msg(input int stall_at, input int stall_len, input bit rnd);
      int          si, cyc, n;
      logic        pst;
      logic [31:0] pd;
      logic [3:0]  pi;
      build_exp();
      obs_d.delete();
      obs_i.delete();
      obs_l.delete();
      si = 0;
      cyc = 0;
      pst = 1'b0;
      pd = '0;
      pi = '0;
      while (obs_d.size() < exp_d.size() && cyc < 3000) begin
         @(negedge clk);
         if (pst) begin
            chk("hold_valid", word_valid, 1);
            chk("hold_data", word_data, pd);
            chk("hold_idx", word_idx, pi);
         end
         in_valid = si < msg.size() && (!rnd || $urandom_range(3) != 0);
         in_data = si < msg.size() ? msg[si] : 8'h00;
         in_last = si == msg.size() - 1;
         word_ready = (cyc >= stall_at && cyc < stall_at + stall_len) ? 1'b0 : (!rnd || $urandom_range(3) != 0);
`ifdef SHA256_PAD_ZERO_LEN_EN
         in_empty = cyc == 0 && msg.size() == 0;
`endif
         #1;
         if (si < msg.size()) chk("in_ready", in_ready, !(word_valid && !word_ready && si % 4 == 3));
         if (si > 0) chk("busy_mid", busy, 1);
         if (in_valid && in_ready) si++;
         if (word_valid && word_ready) begin
            obs_d.push_back(word_data);
            obs_i.push_back(word_idx);
            obs_l.push_back(msg_last);
         end
         pst = word_valid && !word_ready;
         pd = word_data;
         pi = word_idx;
         cyc++;
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      word_ready = 1'b1;
`ifdef SHA256_PAD_ZERO_LEN_EN
      in_empty = 1'b0;
`endif
      chk("word_count", obs_d.size(), exp_d.size());
      n = obs_d.size() < exp_d.size() ? obs_d.size() : exp_d.size();
      for (int w = 0; w < n; w++) begin
         chk($sformatf("word_data[%0d]", w), obs_d[w], exp_d[w]);
         chk($sformatf("word_idx[%0d]", w), obs_i[w], 64'(w % 16));
         chk($sformatf("msg_last[%0d]", w), obs_l[w], exp_l[w]);
      end
      @(negedge clk);
      #1;
      chk("busy_end", busy, 0);
      chk("valid_end", word_valid, 0);
   endtask

   initial begin
      int sent, cyc;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_word_valid", word_valid, 0);
      chk("rst_word_data", word_data, 0);
      chk("rst_word_idx", word_idx, 0);
      chk("rst_msg_last", msg_last, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      #1;
      chk("in_ready_release", in_ready, 0);
      @(negedge clk);
      #1;
      chk("in_ready_rise", in_ready, 1);

      msg = '{8'h61, 8'h62, 8'h63};
      run_msg(-1, 0, 1'b0);
      chk("abc_w0", obs_d[0], 32'h61626380);
      chk("abc_w15", obs_d[15], 32'h00000018);

      msg.delete();
      repeat (55) msg.push_back(8'h00);
      run_msg(-1, 0, 1'b0);
      chk("z55_w13", obs_d[13], 32'h00000080);
      chk("z55_w15", obs_d[15], 32'h000001B8);
      chk("z55_last", obs_l[15], 1);

      msg.delete();
      repeat (56) msg.push_back(8'h00);
      run_msg(-1, 0, 1'b0);
      chk("z56_w14", obs_d[14], 32'h80000000);
      chk("z56_last_b1", obs_l[14], 0);
      chk("z56_w31", obs_d[31], 32'h000001C0);
      chk("z56_last_b2", obs_l[16], 1);

      msg.delete();
      repeat (64) msg.push_back(8'hFF);
      run_msg(-1, 0, 1'b0);
      chk("f64_w0", obs_d[0], 32'hFFFFFFFF);
      chk("f64_w16", obs_d[16], 32'h80000000);
      chk("f64_w31", obs_d[31], 32'h00000200);
      chk("f64_last_b1", obs_l[15], 0);

      msg.delete();
      repeat (40) msg.push_back(8'($urandom));
      run_msg(12, 10, 1'b0);

      for (int k = 0; k < 6; k++) begin
         msg.delete();
         repeat ($urandom_range(1, 140)) msg.push_back(8'($urandom));
         run_msg(k * 7, k, 1'b1);
      end

      sent = 0;
      cyc = 0;
      while (sent < 20 && cyc < 200) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data = 8'($urandom);
         in_last = 1'b0;
         word_ready = 1'b1;
         #1;
         if (in_ready) sent++;
         cyc++;
      end
      chk("partial_sent", sent, 20);
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", word_valid, 0);
      chk("mid_rst_ready", in_ready, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_data", word_data, 0);
      chk("mid_rst_idx", word_idx, 0);
      chk("mid_rst_last", msg_last, 0);
      @(negedge clk);
      rst_n = 1'b1;
      msg = '{8'h61, 8'h62, 8'h63};
      run_msg(-1, 0, 1'b0);
      chk("abc2_w0", obs_d[0], 32'h61626380);
      chk("abc2_w15", obs_d[15], 32'h00000018);

`ifdef SHA256_PAD_ZERO_LEN_EN
      msg.delete();
      run_msg(-1, 0, 1'b0);
      chk("empty_w0", obs_d[0], 32'h80000000);
      chk("empty_w15", obs_d[15], 32'h00000000);
      chk("empty_last", obs_l[0], 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
